// File: rtl/output_slew_limiter_if.sv
// Sample-rate bus between the network core and the output slew limiter:
// strobe and targets in, limited outputs and status pulses out.
interface output_slew_limiter_if #(
  parameter int unsigned W = 16
) ();
  logic                sample_clk;
  logic signed [W-1:0] sample_in0;
  logic signed [W-1:0] sample_in1;
  logic signed [W-1:0] sample_in2;
  logic signed [W-1:0] sample_in3;
  logic signed [W-1:0] sample_out0;
  logic signed [W-1:0] sample_out1;
  logic signed [W-1:0] sample_out2;
  logic signed [W-1:0] sample_out3;
  logic                done;
  logic                overrun;

  modport master (
    output sample_clk,
    output sample_in0, sample_in1, sample_in2, sample_in3,
    input  sample_out0, sample_out1, sample_out2, sample_out3,
    input  done, overrun
  );

  modport slave (
    input  sample_clk,
    input  sample_in0, sample_in1, sample_in2, sample_in3,
    output sample_out0, sample_out1, sample_out2, sample_out3,
    output done, overrun
  );
endinterface

// File: rtl/output_slew_limiter.sv
// Four-channel slew limiter and saturator, sequenced through one shared
// subtract/clamp/add datapath; all four outputs commit together.
module output_slew_limiter #(
  parameter int unsigned W        = 16,
  parameter int unsigned MAX_STEP = 512,
  parameter int unsigned LIMIT    = 32000
) (
  input logic                  clk,
  input logic                  rst,
  output_slew_limiter_if.slave io
);

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 2;
  localparam int unsigned DW  = W + 1;

  localparam logic signed [DW-1:0] STEP_P = DW'(MAX_STEP);
  localparam logic signed [DW-1:0] STEP_N = -STEP_P;
  localparam logic signed [DW-1:0] LIM_P  = DW'(LIMIT);
  localparam logic signed [DW-1:0] LIM_N  = -LIM_P;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIFF,
    S_STEP,
    S_COMMIT
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        ch_q, ch_d;
  logic                 prev_q;
  logic signed [W-1:0]  tgt_q  [NCH];
  logic signed [W-1:0]  tgt_d  [NCH];
  logic signed [W-1:0]  work_q [NCH];
  logic signed [W-1:0]  work_d [NCH];
  logic signed [W-1:0]  out_q  [NCH];
  logic signed [W-1:0]  out_d  [NCH];
  logic signed [DW-1:0] diff_q, diff_d;
  logic                 done_q, done_d;
  logic                 ovr_q, ovr_d;

  logic                 edge_c;
  logic signed [W-1:0]  in_c [NCH];
  logic signed [DW-1:0] diff_c;
  logic signed [DW-1:0] step_c;
  logic signed [DW-1:0] sum_c;
  logic signed [W-1:0]  sat_c;

  assign in_c[0] = io.sample_in0;
  assign in_c[1] = io.sample_in1;
  assign in_c[2] = io.sample_in2;
  assign in_c[3] = io.sample_in3;

  assign edge_c = io.sample_clk & ~prev_q;

  // Shared datapath: widened difference, step clamp, widened sum, saturation.
  // Both operands always come from committed outputs, never from work.
  always_comb begin
    diff_c = DW'(tgt_q[ch_q]) - DW'(out_q[ch_q]);

    if (diff_q > STEP_P) begin
      step_c = STEP_P;
    end else if (diff_q < STEP_N) begin
      step_c = STEP_N;
    end else begin
      step_c = diff_q;
    end

    sum_c = DW'(out_q[ch_q]) + step_c;

    if (sum_c > LIM_P) begin
      sat_c = W'(LIM_P);
    end else if (sum_c < LIM_N) begin
      sat_c = W'(LIM_N);
    end else begin
      sat_c = W'(sum_c);
    end
  end

  // Sequencer; a strobe edge preempts whatever the sequencer is doing.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    diff_d  = diff_q;
    tgt_d   = tgt_q;
    work_d  = work_q;
    out_d   = out_q;
    done_d  = 1'b0;
    ovr_d   = 1'b0;

    if (edge_c) begin
      tgt_d   = in_c;
      ch_d    = '0;
      state_d = S_DIFF;
      ovr_d   = (state_q != S_IDLE);
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_DIFF: begin
          diff_d  = diff_c;
          state_d = S_STEP;
        end
        S_STEP: begin
          work_d[ch_q] = sat_c;
          if (ch_q == CW'(NCH - 1)) begin
            state_d = S_COMMIT;
          end else begin
            ch_d    = ch_q + CW'(1);
            state_d = S_DIFF;
          end
        end
        S_COMMIT: begin
          out_d   = work_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      prev_q  <= 1'b0;
      diff_q  <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        tgt_q[i]  <= '0;
        work_q[i] <= '0;
        out_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      prev_q  <= io.sample_clk;
      diff_q  <= diff_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      for (int i = 0; i < NCH; i++) begin
        tgt_q[i]  <= tgt_d[i];
        work_q[i] <= work_d[i];
        out_q[i]  <= out_d[i];
      end
    end
  end

  assign io.sample_out0 = out_q[0];
  assign io.sample_out1 = out_q[1];
  assign io.sample_out2 = out_q[2];
  assign io.sample_out3 = out_q[3];
  assign io.done        = done_q;
  assign io.overrun     = ovr_q;

endmodule

// File: tb/tb_output_slew_limiter.sv
// Bench for output_slew_limiter: directed scenarios plus random strobes and
// resets, checked every cycle against a timeline model of the update rules.
module tb_output_slew_limiter;

  localparam int W        = 16;
  localparam int MAX_STEP = 512;
  localparam int LIMIT    = 32000;
  localparam int LATENCY  = 9;
  localparam int NLIT     = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;

  output_slew_limiter_if #(.W(W)) tb_if ();

  output_slew_limiter #(
    .W(W), .MAX_STEP(MAX_STEP), .LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (tb_if)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Hand-computed expectations, indexed by commit number.
  bit [3:0] lit_mask [NLIT];
  int       lit_val  [NLIT][4];

  function automatic int slew(int cur, int tgt);
    int d;
    int s;
    d = tgt - cur;
    if (d > MAX_STEP) d = MAX_STEP;
    else if (d < -MAX_STEP) d = -MAX_STEP;
    s = cur + d;
    if (s > LIMIT) s = LIMIT;
    else if (s < -LIMIT) s = -LIMIT;
    return s;
  endfunction

  // Model + compare process: an edge schedules a commit LATENCY cycles
  // later; a newer edge (or reset) cancels the pending one.
  initial begin : compare
    int  m_out [4];
    int  m_new [4];
    int  in_v  [4];
    int  act   [4];
    bit  m_prev, m_pend, e_done, e_ovr, armed, ed;
    int  m_cnt, commit_no;
    armed = 0; commit_no = 0; m_prev = 0; m_pend = 0; m_cnt = 0;
    e_done = 0; e_ovr = 0;
    for (int i = 0; i < 4; i++) begin m_out[i] = 0; m_new[i] = 0; end
    forever begin
      @(posedge clk);
      in_v[0] = int'(tb_if.sample_in0);
      in_v[1] = int'(tb_if.sample_in1);
      in_v[2] = int'(tb_if.sample_in2);
      in_v[3] = int'(tb_if.sample_in3);
      if (rst) begin
        for (int i = 0; i < 4; i++) m_out[i] = 0;
        m_prev = 0; m_pend = 0; m_cnt = 0; e_done = 0; e_ovr = 0;
        armed = 1;
      end else if (armed) begin
        e_done = 0; e_ovr = 0;
        ed = tb_if.sample_clk && !m_prev;
        m_prev = tb_if.sample_clk;
        if (ed) begin
          e_ovr  = m_pend;
          m_pend = 1;
          m_cnt  = 0;
          for (int i = 0; i < 4; i++) m_new[i] = slew(m_out[i], in_v[i]);
        end else if (m_pend) begin
          m_cnt++;
          if (m_cnt == LATENCY) begin
            m_out  = m_new;
            e_done = 1;
            m_pend = 0;
          end
        end
      end
      #1;
      if (armed) begin
        act[0] = int'(tb_if.sample_out0);
        act[1] = int'(tb_if.sample_out1);
        act[2] = int'(tb_if.sample_out2);
        act[3] = int'(tb_if.sample_out3);
        for (int i = 0; i < 4; i++) begin
          n_chk++;
          if (act[i] != m_out[i]) begin
            n_fail++;
            $display("FAIL sample_out%0d @%0t: got %0d expected %0d", i, $time, act[i], m_out[i]);
          end
        end
        n_chk++;
        if (tb_if.done !== e_done) begin
          n_fail++;
          $display("FAIL done @%0t: got %b expected %b", $time, tb_if.done, e_done);
        end
        n_chk++;
        if (tb_if.overrun !== e_ovr) begin
          n_fail++;
          $display("FAIL overrun @%0t: got %b expected %b", $time, tb_if.overrun, e_ovr);
        end
        if (e_done) begin
          if (commit_no < NLIT) begin
            for (int i = 0; i < 4; i++) begin
              if (lit_mask[commit_no][i]) begin
                n_chk++;
                if (act[i] != lit_val[commit_no][i]) begin
                  n_fail++;
                  $display("FAIL literal commit%0d out%0d: got %0d expected %0d", commit_no, i, act[i], lit_val[commit_no][i]);
                end
                n_chk++;
                if (m_out[i] != lit_val[commit_no][i]) begin
                  n_fail++;
                  $display("FAIL model commit%0d out%0d: model %0d expected %0d", commit_no, i, m_out[i], lit_val[commit_no][i]);
                end
              end
            end
          end
          commit_no++;
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_in(int a, int b, int c, int d);
    tb_if.sample_in0 = W'(a);
    tb_if.sample_in1 = W'(b);
    tb_if.sample_in2 = W'(c);
    tb_if.sample_in3 = W'(d);
  endtask

  task automatic pulse(int hi, int lo);
    tb_if.sample_clk = 1'b1;
    cyc(hi);
    tb_if.sample_clk = 1'b0;
    cyc(lo);
  endtask

  task automatic lit(int k, int ch, int v);
    lit_mask[k][ch] = 1'b1;
    lit_val[k][ch]  = v;
  endtask

  initial begin : stim
    int k;
    tb_if.sample_clk = 1'b0;
    set_in(0, 0, 0, 0);
    rst = 1'b1;
    cyc(1);

    // Reset with every input nonzero and the strobe held high.
    set_in(1234, -777, 555, -99);
    tb_if.sample_clk = 1'b1;
    cyc(2);
    rst = 1'b0;
    tb_if.sample_clk = 1'b0;
    cyc(6);

    // Slew up on channel 0.
    k = 0;
    set_in(1000, 0, 0, 0);
    lit(0, 0, 512);  lit(0, 1, 0);
    lit(1, 0, 1000);
    lit(2, 0, 1000);
    repeat (3) pulse(5, 15);
    k = 3;

    // Small negative move and a large positive target from zero.
    set_in(1000, -300, 16'sh1F40, 0);
    lit(k, 0, 1000); lit(k, 1, -300); lit(k, 2, 512); lit(k, 3, 0);
    pulse(5, 15);
    k++;

    // Walk channel 0 to 31800, then push against the limit.
    set_in(31800, -300, 16'sh1F40, 0);
    lit(k + 60, 0, 31800);
    repeat (61) pulse(5, 15);
    k += 61;
    set_in(32767, -300, 16'sh1F40, 0);
    lit(k, 0, 32000); lit(k + 1, 0, 32000);
    repeat (2) pulse(5, 15);
    k += 2;

    // Full-scale swing from +32000 toward -32768.
    set_in(-32768, -300, 16'sh1F40, 0);
    lit(k, 0, 31488);
    pulse(5, 15);
    k++;

    // Overrun: second edge four cycles after the first; second capture wins.
    lit(k, 0, 31000);
    pulse(1, 3);
    set_in(31000, -300, 16'sh1F40, 0);
    pulse(5, 15);
    k++;

    // Random targets, strobe periods and occasional resets.
    for (int it = 0; it < 200; it++) begin
      set_in(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
             int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
      end
      pulse(int'($urandom_range(1, 4)), int'($urandom_range(1, 16)));
    end
    tb_if.sample_clk = 1'b0;
    cyc(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
